// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//
// Time-multiplexed scan controller for a single shared hex-to-7-segment
// decoder. Two requesters (A and B) write {blank, nibble} entries into an
// NDIG-entry digit buffer through a round-robin arbitrated req/ack port.
// Independently, a divider/scanner walks the buffer one digit every
// SCAN_DIV clocks and presents that digit's nibble, blank flag and a
// one-hot digit enable.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous active-high reset, clears all state
//   req_a/b          write request from requester A/B
//   idx_a/b [IW]     target digit index
//   val_a/b [4]      nibble to store
//   blk_a/b          blank flag to store (1 = digit dark)
//   ack_a/b          one-cycle accept pulse, high the cycle after the grant
//   dig_val [4]      nibble of the currently scanned digit
//   dig_blank        blank flag of the currently scanned digit
//   dig_sel [NDIG]   one-hot digit enable, bit i = digit i
//   frame            one-cycle pulse after the scan wraps back to digit 0
module display_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1000,
  localparam int IW      = $clog2(NDIG)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_a,
  input  logic [IW-1:0]   idx_a,
  input  logic [3:0]      val_a,
  input  logic            blk_a,
  output logic            ack_a,
  input  logic            req_b,
  input  logic [IW-1:0]   idx_b,
  input  logic [3:0]      val_b,
  input  logic            blk_b,
  output logic            ack_b,
  output logic [3:0]      dig_val,
  output logic            dig_blank,
  output logic [NDIG-1:0] dig_sel,
  output logic            frame
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  grant_t          last_grant;
  grant_t          last_grant_next;
  logic            elig_a;
  logic            elig_b;
  logic            grant_a;
  logic            grant_b;

  // Each entry is {blank, val[3:0]}
  logic [4:0]      digit_buf [NDIG];

  logic [DW-1:0]   div_cnt;
  logic [IW-1:0]   scan_idx;
  logic            div_tc;

  // Last-grant register; resets to B so that A wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_B;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // A port that is currently being acked is not eligible, which forces at
  // least one idle cycle between two accepts on the same port and lets the
  // requester swap in its next write while ack is high.
  always_comb begin
    elig_a          = req_a & ~ack_a;
    elig_b          = req_b & ~ack_b;
    grant_a         = 1'b0;
    grant_b         = 1'b0;
    last_grant_next = last_grant;
    if (elig_a && (!elig_b || last_grant == GRANT_B)) begin
      grant_a         = 1'b1;
      last_grant_next = GRANT_A;
    end else if (elig_b) begin
      grant_b         = 1'b1;
      last_grant_next = GRANT_B;
    end
  end

  // Ack pulses are simply the grants delayed by one clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
    end else begin
      ack_a <= grant_a;
      ack_b <= grant_b;
    end
  end

  // Digit buffer: cleared to blank zeros, written by at most one port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) begin
        digit_buf[i] <= 5'b1_0000;
      end
    end else if (grant_a) begin
      digit_buf[idx_a] <= {blk_a, val_a};
    end else if (grant_b) begin
      digit_buf[idx_b] <= {blk_b, val_b};
    end
  end

  assign div_tc = (div_cnt == DIV_LAST);

  // Dwell divider and scan index. Runs free of the write port entirely.
  // NDIG is a power of two, so the index wraps by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      scan_idx <= '0;
      frame    <= 1'b0;
    end else begin
      frame <= div_tc && (scan_idx == IDX_LAST);
      if (div_tc) begin
        div_cnt  <= '0;
        scan_idx <= scan_idx + 1'b1;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end
    end
  end

  assign dig_sel   = NDIG'(1) << scan_idx;
  assign dig_val   = digit_buf[scan_idx][3:0];
  assign dig_blank = digit_buf[scan_idx][4];

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//
// Randomized self-checking bench for display_scan_ctrl (NDIG=4, SCAN_DIV=3).
// A reference model tracks the digit buffer as a plain array, the scan
// position as arithmetic on the number of clocks since reset, and the
// arbiter as the round-robin rule on eligible ports. Two behavioural
// requesters hold their request until they see the expected ack.
module tb_display_scan_ctrl;

  localparam int NDIG = 4;
  localparam int SD   = 3;
  localparam int IW   = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_a, req_b;
  logic [IW-1:0]   idx_a, idx_b;
  logic [3:0]      val_a, val_b;
  logic            blk_a, blk_b;
  logic            ack_a, ack_b;
  logic [3:0]      dig_val;
  logic            dig_blank;
  logic [NDIG-1:0] dig_sel;
  logic            frame;

  display_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SD)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .req_a     (req_a),
    .idx_a     (idx_a),
    .val_a     (val_a),
    .blk_a     (blk_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .idx_b     (idx_b),
    .val_b     (val_b),
    .blk_b     (blk_b),
    .ack_b     (ack_b),
    .dig_val   (dig_val),
    .dig_blank (dig_blank),
    .dig_sel   (dig_sel),
    .frame     (frame)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         edges;
  logic [3:0] m_val   [NDIG];
  logic       m_blank [NDIG];
  logic       m_ack_a, m_ack_b;
  logic       m_last_b;

  // Behavioural requesters
  bit         pend_a, pend_b;
  logic [1:0] a_idx, b_idx;
  logic [3:0] a_val, b_val;
  logic       a_blk, b_blk;
  bit         a_toggle;
  int         mode;
  bit         want_reset;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NDIG; i++) begin
      m_val[i]   = 4'h0;
      m_blank[i] = 1'b1;
    end
    m_ack_a  = 1'b0;
    m_ack_b  = 1'b0;
    m_last_b = 1'b1;
    edges    = 0;
  endtask

  // One clock edge of the reference: round-robin among eligible ports.
  task automatic modelEdge();
    bit ea, eb, ga, gb;
    ea = req_a && !m_ack_a;
    eb = req_b && !m_ack_b;
    ga = 0;
    gb = 0;
    if (ea && eb) begin
      if (m_last_b) ga = 1; else gb = 1;
    end else if (ea) begin
      ga = 1;
    end else if (eb) begin
      gb = 1;
    end
    if (ga) begin
      m_val[idx_a]   = val_a;
      m_blank[idx_a] = blk_a;
      m_last_b       = 1'b0;
    end
    if (gb) begin
      m_val[idx_b]   = val_b;
      m_blank[idx_b] = blk_b;
      m_last_b       = 1'b1;
    end
    m_ack_a = ga;
    m_ack_b = gb;
    edges++;
  endtask

  task automatic checkAll();
    int s;
    s = (edges / SD) % NDIG;
    checkOutput("dig_sel",   32'(dig_sel),   32'(1 << s));
    checkOutput("dig_val",   32'(dig_val),   32'(m_val[s]));
    checkOutput("dig_blank", 32'(dig_blank), 32'(m_blank[s]));
    checkOutput("ack_a",     32'(ack_a),     32'(m_ack_a));
    checkOutput("ack_b",     32'(ack_b),     32'(m_ack_b));
    checkOutput("frame",     32'(frame),     32'((edges > 0) && (edges % (NDIG * SD) == 0)));
  endtask

  // Requesters retire a write only when the expected ack is seen, then may
  // start a fresh one in the same cycle (req stays high).
  task automatic applyStimulus();
    if (pend_a && m_ack_a) pend_a = 0;
    if (pend_b && m_ack_b) pend_b = 0;
    if (!pend_a) begin
      if (mode == 1 && ($urandom % 3) == 0) begin
        pend_a = 1;
        a_idx  = 2'($urandom % NDIG);
        a_val  = 4'($urandom);
        a_blk  = (($urandom % 4) == 0);
      end else if (mode == 2) begin
        pend_a   = 1;
        a_idx    = 2'd1;
        a_val    = a_toggle ? 4'hA : 4'h5;
        a_blk    = 1'b0;
        a_toggle = !a_toggle;
      end
    end
    if (!pend_b && mode == 1 && ($urandom % 3) == 0) begin
      pend_b = 1;
      b_idx  = 2'($urandom % NDIG);
      b_val  = 4'($urandom);
      b_blk  = (($urandom % 4) == 0);
    end
    req_a = pend_a;
    idx_a = a_idx;
    val_a = a_val;
    blk_a = a_blk;
    req_b = pend_b;
    idx_b = b_idx;
    val_b = b_val;
    blk_b = b_blk;
    reset = want_reset;
    if (reset) modelReset();
  endtask

  task automatic runCycle();
    @(negedge clock);
    checkAll();
    applyStimulus();
    @(posedge clock);
    if (!reset) modelEdge();
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    req_a = 0; req_b = 0;
    idx_a = 0; idx_b = 0;
    val_a = 0; val_b = 0;
    blk_a = 0; blk_b = 0;
    pend_a = 0; pend_b = 0;
    a_idx = 0; b_idx = 0; a_val = 0; b_val = 0; a_blk = 0; b_blk = 0;
    a_toggle = 0;
    mode = 0;
    modelReset();

    // Reset held, then idle scanning across two full frames
    want_reset = 1;
    repeat (3) runCycle();
    want_reset = 0;
    repeat (30) runCycle();

    // Simultaneous writes to digit 0 straight out of reset: A first, B wins
    want_reset = 1;
    repeat (2) runCycle();
    want_reset = 0;
    pend_a = 1; a_idx = 2'd0; a_val = 4'h1; a_blk = 1'b0;
    pend_b = 1; b_idx = 2'd0; b_val = 4'h2; b_blk = 1'b0;
    repeat (16) runCycle();

    // Mixed random traffic from both requesters
    mode = 1;
    repeat (300) runCycle();

    // A streams back-to-back writes while B stays idle
    mode = 2;
    repeat (40) runCycle();

    // Drain, then reset mid-dwell on digit 3 with a fresh B request pending
    mode = 0;
    repeat (6) runCycle();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      runCycle();
      if ((edges / SD) % NDIG == 3 && edges % SD == 1) found = 1;
    end
    checkOutput("reach_digit3", 32'(found), 32'd1);
    pend_a = 0;
    pend_b = 1; b_idx = 2'd3; b_val = 4'hC; b_blk = 1'b0;
    want_reset = 1;
    repeat (3) runCycle();
    want_reset = 0;
    repeat (20) runCycle();

    // More random traffic after the mid-run reset
    mode = 1;
    repeat (200) runCycle();
    mode = 0;
    repeat (10) runCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed controller for the shared hex-to-7-segment decoder. It holds an NDIG-digit buffer that two requesters write through an arbitrated req/ack port. It scans the buffer one digit at a time, presenting the current nibble, its blank flag and a one-hot digit select, so a single decoder instance drives all digit positions. It sits between the datapath/debug logic and the decoder plus digit-enable pins.

## Interface
- NDIG, 4: digits in buffer; power of two, ≥2; IW = clog2(NDIG)
- SCAN_DIV, 1000: clock cycles each digit stays selected; ≥1
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_a  in  1  requester A write request
- idx_a  in  IW  requester A target digit
- val_a  in  4  requester A nibble
- blk_a  in  1  requester A blank flag (1 = digit dark)
- ack_a  out 1  one-cycle accept pulse to A
- req_b, idx_b, val_b, blk_b, ack_b: same for requester B
- dig_val    out 4     nibble of scanned digit, to decoder input
- dig_blank  out 1     blank flag of scanned digit
- dig_sel    out NDIG  one-hot active-high digit enable, bit i = digit i
- frame      out 1     one-cycle pulse when scan wraps to digit 0

## Operation
- Buffer: NDIG entries of {blank, val[3:0]}. Reset value: val=0, blank=1.
- Eligibility: port X is eligible in a cycle when req_x=1 and ack_x=0. A port can therefore never be granted in two consecutive cycles.
- Arbiter: round-robin with a 1-bit last-grant register. Reset value is B, so A wins the first tie.
  - Only one eligible port: that port is granted.
  - Both eligible: the port other than last-grant is granted.
  - Neither eligible: no grant, last-grant holds.
- Grant on edge k:
  - buffer[idx] <= {blk, val} of the granted port.
  - ack of that port = 1 for the cycle after edge k.
  - last-grant updates.
- Requester holds req/idx/val/blk stable until it sees ack. It may keep req high to issue back-to-back writes; each one is accepted at most every other cycle.
- Scanner: divider counts 0..SCAN_DIV-1.
  - At terminal count the divider returns to 0 and scan index advances by 1 mod NDIG.
  - When the scan index goes NDIG-1 -> 0, frame=1 for the next cycle.
- Outputs are decoded from registers with no further latch:
  - dig_sel = onehot(scan index)
  - dig_val = buffer[scan index].val
  - dig_blank = buffer[scan index].blank
- Write to the currently scanned digit: new value appears on dig_val/dig_blank the cycle after the grant edge.
- SCAN_DIV=1: scan index advances every cycle.

## Timing
- Reset values, held while reset=1:
  - ack_a=0, ack_b=0, frame=0
  - dig_sel=one-hot bit 0, dig_val=0, dig_blank=1
  - divider=0, scan index=0, last-grant=B
- Reset asserted mid-handshake: pending request is dropped, no ack pulse, buffer cleared. After release the requester must still see ack before it counts the write as done.
- Write latency: req rises before edge k and port is eligible -> grant at edge k. ack is high and buffer is updated in cycle k+1.
- Arbitration wait: losing port is granted at edge k+1, ack in cycle k+2, unless it became ineligible.
- Same-index writes on consecutive grants: later grant wins.
- Dwell: each digit is selected for exactly SCAN_DIV cycles. Full frame = NDIG*SCAN_DIV cycles.
- frame period = NDIG*SCAN_DIV cycles. First pulse after reset at cycle NDIG*SCAN_DIV.
- Scanner runs independently of the arbiter. Writes never stall or reset the divider.

## Test plan
- Reset, NDIG=4, SCAN_DIV=3, no requests -> dig_sel steps 0001,0010,0100,1000 every 3 cycles. dig_blank=1 and dig_val=0 throughout. frame pulses at cycles 12, 24.
- A writes idx=2 val=0x9 blk=0 -> ack_a exactly one cycle. When dig_sel=0100: dig_val=9, dig_blank=0. Other digits stay blank.
- A and B request simultaneously from reset (A idx0=0x1, B idx0=0x2) -> A acked first, B next cycle. Final buffer[0]=0x2.
- A holds req high continuously with val=0x5 then 0xA, while B idles -> ack_a in alternate cycles, never two cycles in a row.
- Write idx=1 while dig_sel=0010 -> dig_val changes the cycle after the grant edge. Divider phase is unaffected.
- Assert reset while req_b is pending and mid-dwell on digit 3 -> no ack_b. Outputs return to sel=0001, val=0, blank=1. After release B is granted on the first edge.
